// File: rtl/hazard_flush_controller_pkg.sv
// Shared types and constants for the ID-stage hazard/flush controller.
package hazard_flush_controller_pkg;

   localparam int unsigned REG_ADDR_W    = 4;
   localparam int unsigned CNT_W_DEF     = 32;
   localparam int unsigned MAX_STALL_DEF = 3;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef enum logic [1:0] {
      CTRL_RUN   = 2'd0,
      CTRL_STALL = 2'd1,
      CTRL_FLUSH = 2'd2
   } ctrl_state_e;

   // Shadow of one downstream pipeline slot (EX or MEM)
   typedef struct packed {
      logic      valid;
      logic      wb_en;
      logic      mem_r_en;
      reg_addr_t dest;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '0;

   // Build a slot from ID fields; a bubble in ID yields an all-zero slot
   function automatic slot_t id_to_slot(input logic vld, input logic wb, input logic ld,
                                        input reg_addr_t dest);
      slot_t s;
      s.valid    = vld;
      s.wb_en    = vld & wb;
      s.mem_r_en = vld & ld;
      s.dest     = vld ? dest : '0;
      return s;
   endfunction

endpackage

// File: rtl/hazard_flush_controller_if.sv
// ID-stage decode info in, pipeline control and status out.
interface hazard_flush_controller_if #(
   parameter int unsigned CNT_W = hazard_flush_controller_pkg::CNT_W_DEF
) ();
   import hazard_flush_controller_pkg::*;

   logic        fwd_en;
   logic        id_valid;
   reg_addr_t   id_src_1;
   reg_addr_t   id_src_2;
   logic        id_src1_used;
   logic        id_two_src;
   logic        id_wb_en;
   logic        id_mem_r_en;
   reg_addr_t   id_dest;
   logic        ex_branch_taken;

   logic        hazard;
   logic        flush;
   ctrl_state_e ctrl_state;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;
   logic        stall_err;

   modport master (
      output fwd_en, id_valid, id_src_1, id_src_2, id_src1_used, id_two_src,
             id_wb_en, id_mem_r_en, id_dest, ex_branch_taken,
      input  hazard, flush, ctrl_state, stall_count, flush_count, stall_err
   );

   modport slave (
      input  fwd_en, id_valid, id_src_1, id_src_2, id_src1_used, id_two_src,
             id_wb_en, id_mem_r_en, id_dest, ex_branch_taken,
      output hazard, flush, ctrl_state, stall_count, flush_count, stall_err
   );

endinterface

// File: rtl/hazard_slot_cmp.sv
// Compares one shadowed slot against the two ID source registers.
module hazard_slot_cmp
   import hazard_flush_controller_pkg::*;
(
   input  slot_t     slot_i,
   input  logic      need_load_i,
   input  reg_addr_t src_1_i,
   input  reg_addr_t src_2_i,
   input  logic      src1_used_i,
   input  logic      two_src_i,
   output logic      match_1_o,
   output logic      match_2_o
);

   logic writer_c;

   // A slot matters only if it writes back (and is a load when need_load_i is set)
   always_comb begin
      writer_c  = slot_i.valid & slot_i.wb_en & (~need_load_i | slot_i.mem_r_en);
      match_1_o = writer_c & src1_used_i & (slot_i.dest == src_1_i);
      match_2_o = writer_c & two_src_i   & (slot_i.dest == src_2_i);
   end

endmodule

// File: rtl/hazard_flush_controller.sv
// Hazard detection, branch flush, perf counters and stall watchdog beside ID.
module hazard_flush_controller
   import hazard_flush_controller_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned MAX_STALL = MAX_STALL_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   hazard_flush_controller_if.slave  bus
);

   localparam int unsigned WD_LIMIT = MAX_STALL + 1;
   localparam int unsigned WD_W     = $clog2(WD_LIMIT + 1);

   slot_t            ex_q, ex_d, mem_q, mem_d;
   ctrl_state_e      state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [WD_W-1:0]  run_q, run_d;
   logic             err_q, err_d;

   logic ex_m1_c, ex_m2_c, mem_m1_c, mem_m2_c;
   logic raw_hz_c, hazard_c, flush_c;

   // EX slot: with forwarding only a load in EX can still hurt
   hazard_slot_cmp u_ex_cmp (
      .slot_i      (ex_q),
      .need_load_i (bus.fwd_en),
      .src_1_i     (bus.id_src_1),
      .src_2_i     (bus.id_src_2),
      .src1_used_i (bus.id_src1_used),
      .two_src_i   (bus.id_two_src),
      .match_1_o   (ex_m1_c),
      .match_2_o   (ex_m2_c)
   );

   // MEM slot: any writer counts; ignored entirely when forwarding is on
   hazard_slot_cmp u_mem_cmp (
      .slot_i      (mem_q),
      .need_load_i (1'b0),
      .src_1_i     (bus.id_src_1),
      .src_2_i     (bus.id_src_2),
      .src1_used_i (bus.id_src1_used),
      .two_src_i   (bus.id_two_src),
      .match_1_o   (mem_m1_c),
      .match_2_o   (mem_m2_c)
   );

   // Hazard/flush decision; a taken branch suppresses the stall
   always_comb begin
      raw_hz_c = (ex_m1_c | ex_m2_c) | (~bus.fwd_en & (mem_m1_c | mem_m2_c));
      flush_c  = bus.ex_branch_taken;
      hazard_c = raw_hz_c & bus.id_valid & ~bus.ex_branch_taken;
   end

   // Slot advance: a stall or flush injects a bubble into EX
   always_comb begin
      mem_d = ex_q;
      ex_d  = id_to_slot(bus.id_valid, bus.id_wb_en, bus.id_mem_r_en, bus.id_dest);
      if (flush_c || hazard_c) begin
         ex_d = SLOT_EMPTY;
      end
   end

   // Next-state logic: state records the decision of the previous cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         CTRL_RUN: begin
            if (flush_c)       state_d = CTRL_FLUSH;
            else if (hazard_c) state_d = CTRL_STALL;
         end
         CTRL_STALL: begin
            if (flush_c)       state_d = CTRL_FLUSH;
            else if (hazard_c) state_d = CTRL_STALL;
            else               state_d = CTRL_RUN;
         end
         CTRL_FLUSH: begin
            if (flush_c)       state_d = CTRL_FLUSH;
            else if (hazard_c) state_d = CTRL_STALL;
            else               state_d = CTRL_RUN;
         end
         default: state_d = CTRL_RUN;
      endcase
   end

   // Perf counters (wrapping) and consecutive-stall watchdog with sticky error
   always_comb begin
      stall_cnt_d = stall_cnt_q + CNT_W'(hazard_c);
      flush_cnt_d = flush_cnt_q + CNT_W'(flush_c);
      run_d       = '0;
      if (hazard_c) begin
         run_d = (run_q == WD_W'(WD_LIMIT)) ? run_q : run_q + WD_W'(1);
      end
      err_d = err_q | (run_d == WD_W'(WD_LIMIT));
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q        <= SLOT_EMPTY;
         mem_q       <= SLOT_EMPTY;
         state_q     <= CTRL_RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         run_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         run_q       <= run_d;
         err_q       <= err_d;
      end
   end

   assign bus.hazard      = hazard_c;
   assign bus.flush       = flush_c;
   assign bus.ctrl_state  = state_q;
   assign bus.stall_count = stall_cnt_q;
   assign bus.flush_count = flush_cnt_q;
   assign bus.stall_err   = err_q;

endmodule

// File: tb/tb_hazard_flush_controller.sv
// Bench for hazard_flush_controller: directed table, corner sequences, random vs model.
module tb_hazard_flush_controller;
   import hazard_flush_controller_pkg::*;

   localparam int unsigned MAX_ST = 3;

   logic clk;
   logic rst;

   hazard_flush_controller_if #(.CNT_W(32)) bus ();

   hazard_flush_controller #(.CNT_W(32), .MAX_STALL(MAX_ST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       fwd, vld;
      logic [3:0] s1, s2;
      logic       u1, two, wb, ld;
      logic [3:0] dst;
      logic       br;
      logic       ehz, efl;
      logic [1:0] est;
      int         esc, efc;
   } vec_t;

   // Instruction as seen by the model after it has left ID
   typedef struct {
      bit       v, wb, ld;
      bit [3:0] d;
   } ins_t;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t vecs[21];
   slot_t forced_slot;

   // Model state: issued[0] is the newest instruction past ID, issued[1] the one before
   ins_t issued[$];
   int   m_sc, m_fc, m_state, m_run;
   bit   m_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.fwd_en          = v.fwd;
      bus.id_valid        = v.vld;
      bus.id_src_1        = v.s1;
      bus.id_src_2        = v.s2;
      bus.id_src1_used    = v.u1;
      bus.id_two_src      = v.two;
      bus.id_wb_en        = v.wb;
      bus.id_mem_r_en     = v.ld;
      bus.id_dest         = v.dst;
      bus.ex_branch_taken = v.br;
   endtask

   function automatic vec_t mk(input logic fwd, vld, input int s1, s2,
                               input logic u1, two, wb, ld, input int dst, input logic br);
      vec_t v;
      v = '{fwd, vld, 4'(s1), 4'(s2), u1, two, wb, ld, 4'(dst), br, 1'b0, 1'b0, 2'd0, 0, 0};
      return v;
   endfunction

   function automatic vec_t ex(input vec_t v, input logic hz, fl, input int st, sc, fc);
      vec_t r;
      r = v; r.ehz = hz; r.efl = fl; r.est = 2'(st); r.esc = sc; r.efc = fc;
      return r;
   endfunction

   // Does a finished producer p collide with the ID sources?
   function automatic bit reads(input ins_t p, input vec_t v);
      if (!p.v || !p.wb) return 1'b0;
      return (v.u1 && p.d == v.s1) || (v.two && p.d == v.s2);
   endfunction

   function automatic bit model_hazard(input vec_t v);
      bit raw;
      if (v.fwd) raw = issued[0].ld && reads(issued[0], v);
      else       raw = reads(issued[0], v) || reads(issued[1], v);
      return raw && v.vld && !v.br;
   endfunction

   task automatic model_reset();
      ins_t b;
      b = '{0, 0, 0, 4'd0};
      issued.delete();
      issued.push_back(b);
      issued.push_back(b);
      m_sc = 0; m_fc = 0; m_state = 0; m_run = 0; m_err = 1'b0;
   endtask

   // One cycle, starting 1 time unit after a rising edge, checked against the model
   task automatic step_model(input vec_t v);
      bit   ehz, efl;
      ins_t n;
      drive(v);
      #2;
      ehz = model_hazard(v);
      efl = v.br;
      check("rnd_hazard", 64'(bus.hazard), 64'(ehz));
      check("rnd_flush", 64'(bus.flush), 64'(efl));
      @(posedge clk); #1;
      n = '{v.vld && !ehz && !efl, v.wb, v.ld, v.dst};
      issued.push_front(n);
      void'(issued.pop_back());
      m_sc += int'(ehz);
      m_fc += int'(efl);
      m_state = efl ? 2 : (ehz ? 1 : 0);
      m_run = ehz ? ((m_run >= int'(MAX_ST) + 1) ? m_run : m_run + 1) : 0;
      if (m_run == int'(MAX_ST) + 1) m_err = 1'b1;
      check("rnd_state", 64'(bus.ctrl_state), 64'(m_state));
      check("rnd_stall_count", 64'(bus.stall_count), 64'(m_sc));
      check("rnd_flush_count", 64'(bus.flush_count), 64'(m_fc));
      check("rnd_stall_err", 64'(bus.stall_err), 64'(m_err));
   endtask

   initial begin
      vec_t v;
      rst = 1'b0;
      forced_slot = '{1'b1, 1'b1, 1'b0, 4'd5};
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      //              fwd vld s1 s2 u1 two wb ld dst br        hz fl st sc fc
      vecs[0]  = ex(mk(0, 1, 2, 3, 1, 1, 1, 0, 1, 0),          0, 0, 0, 0, 0);
      vecs[1]  = ex(mk(0, 1, 1, 0, 1, 0, 1, 0, 4, 0),          1, 0, 1, 1, 0);
      vecs[2]  = ex(mk(0, 1, 1, 0, 1, 0, 1, 0, 4, 0),          1, 0, 1, 2, 0);
      vecs[3]  = ex(mk(0, 1, 1, 0, 1, 0, 1, 0, 4, 0),          0, 0, 0, 2, 0);
      vecs[4]  = ex(mk(1, 1, 6, 0, 1, 0, 1, 1, 2, 0),          0, 0, 0, 2, 0);
      vecs[5]  = ex(mk(1, 1, 7, 2, 1, 1, 1, 0, 8, 0),          1, 0, 1, 3, 0);
      vecs[6]  = ex(mk(1, 1, 7, 2, 1, 1, 1, 0, 8, 0),          0, 0, 0, 3, 0);
      vecs[7]  = ex(mk(1, 1, 0, 8, 1, 1, 1, 0, 9, 0),          0, 0, 0, 3, 0);
      vecs[8]  = ex(mk(0, 1, 10, 11, 1, 1, 1, 0, 3, 0),        0, 0, 0, 3, 0);
      vecs[9]  = ex(mk(0, 1, 3, 12, 0, 0, 1, 0, 5, 0),         0, 0, 0, 3, 0);
      vecs[10] = ex(mk(0, 1, 5, 0, 1, 0, 1, 0, 6, 1),          0, 1, 2, 3, 1);
      vecs[11] = ex(mk(0, 1, 6, 0, 1, 0, 1, 0, 7, 0),          0, 0, 0, 3, 1);
      vecs[12] = ex(mk(0, 1, 13, 0, 1, 0, 1, 0, 9, 1),         0, 1, 2, 3, 2);
      vecs[13] = ex(mk(0, 1, 7, 0, 1, 0, 1, 0, 10, 0),         1, 0, 1, 4, 2);
      vecs[14] = ex(mk(0, 1, 7, 0, 1, 0, 1, 0, 10, 1),         0, 1, 2, 4, 3);
      vecs[15] = ex(mk(0, 1, 7, 0, 1, 0, 1, 0, 10, 1),         0, 1, 2, 4, 4);
      vecs[16] = ex(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),          0, 0, 0, 4, 4);
      vecs[17] = ex(mk(0, 1, 2, 0, 1, 0, 1, 0, 1, 0),          0, 0, 0, 4, 4);
      vecs[18] = ex(mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 0),          0, 0, 0, 4, 4);
      vecs[19] = ex(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0),          1, 0, 1, 5, 4);
      vecs[20] = ex(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0),          0, 0, 0, 5, 4);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_hazard", 64'(bus.hazard), 64'd0);
      check("rst_flush", 64'(bus.flush), 64'd0);
      check("rst_state", 64'(bus.ctrl_state), 64'd0);
      check("rst_stall_count", 64'(bus.stall_count), 64'd0);
      check("rst_flush_count", 64'(bus.flush_count), 64'd0);
      check("rst_stall_err", 64'(bus.stall_err), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed table: RAW stall, load-use, unused source, flush over hazard
      for (int i = 0; i < 21; i++) begin
         drive(vecs[i]);
         #2;
         check($sformatf("vec%0d_hazard", i), 64'(bus.hazard), 64'(vecs[i].ehz));
         check($sformatf("vec%0d_flush", i), 64'(bus.flush), 64'(vecs[i].efl));
         @(posedge clk); #1;
         check($sformatf("vec%0d_state", i), 64'(bus.ctrl_state), 64'(vecs[i].est));
         check($sformatf("vec%0d_stall_count", i), 64'(bus.stall_count), 64'(vecs[i].esc));
         check($sformatf("vec%0d_flush_count", i), 64'(bus.flush_count), 64'(vecs[i].efc));
      end

      // Watchdog: EX slot pinned to a writer of R5 while ID keeps reading R5
      force dut.ex_q = forced_slot;
      drive(mk(0, 1, 5, 0, 1, 0, 0, 0, 0, 0));
      for (int k = 1; k <= 5; k++) begin
         #2;
         check($sformatf("wd%0d_hazard", k), 64'(bus.hazard), 64'd1);
         @(posedge clk); #1;
         check($sformatf("wd%0d_stall_err", k), 64'(bus.stall_err), 64'(k >= 4));
      end
      check("wd_stall_count", 64'(bus.stall_count), 64'd10);
      check("wd_state", 64'(bus.ctrl_state), 64'd1);
      release dut.ex_q;
      drive(mk(0, 0, 5, 0, 1, 0, 0, 0, 0, 0));
      for (int k = 0; k < 2; k++) begin
         #2;
         check("wd_after_hazard", 64'(bus.hazard), 64'd0);
         @(posedge clk); #1;
         check("wd_sticky_err", 64'(bus.stall_err), 64'd1);
      end
      check("wd_after_state", 64'(bus.ctrl_state), 64'd0);

      // Asynchronous reset in the middle of a stall
      drive(mk(0, 1, 2, 0, 1, 0, 1, 0, 1, 0));
      @(posedge clk); #1;
      drive(mk(0, 1, 1, 0, 1, 0, 1, 0, 4, 0));
      #2;
      check("mid_hazard_before", 64'(bus.hazard), 64'd1);
      @(posedge clk); #1;
      check("mid_state_before", 64'(bus.ctrl_state), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_hazard", 64'(bus.hazard), 64'd0);
      check("mid_rst_state", 64'(bus.ctrl_state), 64'd0);
      check("mid_rst_stall_count", 64'(bus.stall_count), 64'd0);
      check("mid_rst_flush_count", 64'(bus.flush_count), 64'd0);
      check("mid_rst_stall_err", 64'(bus.stall_err), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      // Random traffic against the behavioural model
      model_reset();
      for (int n = 0; n < 400; n++) begin
         v = mk(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) != 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0));
         step_model(v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
